grayscale_feeder: RTL and testbench

- Initiator and collector for the grayscale converter.
- Accepts packed RGB pixel words from an upstream pixel source and issues each one to the grayscale unit using its start/data_ready protocol.
- Collects the 8-bit gray results and packs four of them into a 32-bit word for the write-back path.
- Sits between the pixel fetch side and the grayscale unit, and between the grayscale unit and the output memory writer.

---
 rtl/grayscale_feeder.sv | 171 +++++++++++++++++
 tb/tb_grayscale_feeder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grayscale_feeder.sv
// -----------------------------------------------------------------------------
// grayscale_feeder
//
// Purpose:
//   This block sits between the pixel fetch side and the grayscale converter.
//   It accepts one packed RGB pixel at a time and sends it to the grayscale
//   unit with a start pulse. It then collects the 8-bit gray results and
//   packs four of them, MSB-first, into a 32-bit word for the write-back path.
//   A partial word can be emitted early with i_flush.
//   A pixel whose result does not arrive in time is recorded as 8'h00, and
//   the sticky timeout flag is set.
//
// Ports:
//   clk                     system clock, rising edge
//   n_rst                   asynchronous active-low reset
//   i_pix_valid             upstream pixel available
//   i_pix_RGB[31:0]         pixel {R, G, B, 8'b0}
//   o_pix_ready             feeder accepts a pixel this cycle (IDLE and no flush)
//   o_grayscale_start       one-cycle start pulse to the grayscale unit
//   o_RGB[31:0]             pixel presented to the grayscale unit
//   i_grayscale_data_ready  grayscale result valid (one-cycle pulse)
//   i_gray[7:0]             grayscale result
//   i_flush                 emit a partially filled word
//   o_word_valid            packed word available
//   o_word[31:0]            packed gray bytes, slot 0 in [31:24]
//   o_word_bytes[2:0]       number of valid bytes in o_word (1..4)
//   i_word_ready            downstream consumes the word
//   o_timeout_err           sticky timeout flag
// -----------------------------------------------------------------------------
module grayscale_feeder #(
   parameter int unsigned TIMEOUT_CYCLES = 32
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        i_pix_valid,
   input  logic [31:0] i_pix_RGB,
   output logic        o_pix_ready,
   output logic        o_grayscale_start,
   output logic [31:0] o_RGB,
   input  logic        i_grayscale_data_ready,
   input  logic [7:0]  i_gray,
   input  logic        i_flush,
   output logic        o_word_valid,
   output logic [31:0] o_word,
   output logic [2:0]  o_word_bytes,
   input  logic        i_word_ready,
   output logic        o_timeout_err
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_OUT
   } state_t;

   state_t        state_q;
   logic [31:0]   rgb_q;
   logic          start_q;
   logic [31:0]   word_q;
   logic [31:0]   word_d;
   logic [2:0]    bytes_q;
   logic          word_valid_q;
   logic          err_q;
   logic [2:0]    idx_q;
   logic [2:0]    idx_inc;
   logic [TW-1:0] timer_q;
   logic          timed_out;
   logic [7:0]    slot_byte;

   // A flush request blocks new pixels, so the flush takes priority over a pixel in the same cycle.
   assign o_pix_ready = (state_q == S_IDLE) && !i_flush;

   // A real result wins over the timeout when both happen in the same cycle.
   assign timed_out = (timer_q == TIMER_LAST);
   assign slot_byte = i_grayscale_data_ready ? i_gray : 8'h00;
   assign idx_inc   = idx_q + 3'd1;

   // This is the word after the current result is placed into slot idx_q.
   // NOTE: assigning the default first makes every path of this always_comb
   // drive word_d, so no latch is inferred.
   always_comb begin
      word_d = word_q;
      case (idx_q[1:0])
         2'd0: word_d[31:24] = slot_byte;
         2'd1: word_d[23:16] = slot_byte;
         2'd2: word_d[15:8]  = slot_byte;
         2'd3: word_d[7:0]   = slot_byte;
         default: word_d = word_q;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments only. Every register
   // then samples the values from before the edge, so the result does not
   // depend on the order in which the blocks are evaluated.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= S_IDLE;
         rgb_q        <= '0;
         start_q      <= 1'b0;
         word_q       <= '0;
         bytes_q      <= '0;
         word_valid_q <= 1'b0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         timer_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_pix_valid && o_pix_ready) begin
                  rgb_q   <= i_pix_RGB;
                  start_q <= 1'b1;
                  state_q <= S_ISSUE;
               end else if (i_flush && (idx_q != 3'd0)) begin
                  bytes_q      <= idx_q;
                  word_valid_q <= 1'b1;
                  state_q      <= S_OUT;
               end
            end

            S_ISSUE: begin
               start_q <= 1'b0;
               timer_q <= '0;
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               if (i_grayscale_data_ready || timed_out) begin
                  if (!i_grayscale_data_ready) begin
                     err_q <= 1'b1;
                  end
                  word_q <= word_d;
                  idx_q  <= idx_inc;
                  if (idx_inc == 3'd4) begin
                     bytes_q      <= 3'd4;
                     word_valid_q <= 1'b1;
                     state_q      <= S_OUT;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            S_OUT: begin
               if (i_word_ready) begin
                  word_valid_q <= 1'b0;
                  word_q       <= '0;
                  bytes_q      <= '0;
                  idx_q        <= '0;
                  state_q      <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_grayscale_start = start_q;
   assign o_RGB             = rgb_q;
   assign o_word_valid      = word_valid_q;
   assign o_word            = word_q;
   assign o_word_bytes      = bytes_q;
   assign o_timeout_err     = err_q;

endmodule

// File: tb/tb_grayscale_feeder.sv
// -----------------------------------------------------------------------------
// tb_grayscale_feeder
//
// This bench drives grayscale_feeder with a behavioural grayscale unit.
// Each accepted pixel queues a response (gray value, latency, drop), and the
// bench keeps its own packing model. That model pushes each expected word to
// a scoreboard, which is popped when the DUT hands a word downstream.
// -----------------------------------------------------------------------------
module tb_grayscale_feeder;

   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        i_pix_valid;
   logic [31:0] i_pix_RGB;
   logic        o_pix_ready;
   logic        o_grayscale_start;
   logic [31:0] o_RGB;
   logic        i_grayscale_data_ready;
   logic [7:0]  i_gray;
   logic        i_flush;
   logic        o_word_valid;
   logic [31:0] o_word;
   logic [2:0]  o_word_bytes;
   logic        i_word_ready;
   logic        o_timeout_err;

   always #5 clk = ~clk;

   grayscale_feeder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk                    (clk),
      .n_rst                  (n_rst),
      .i_pix_valid            (i_pix_valid),
      .i_pix_RGB              (i_pix_RGB),
      .o_pix_ready            (o_pix_ready),
      .o_grayscale_start      (o_grayscale_start),
      .o_RGB                  (o_RGB),
      .i_grayscale_data_ready (i_grayscale_data_ready),
      .i_gray                 (i_gray),
      .i_flush                (i_flush),
      .o_word_valid           (o_word_valid),
      .o_word                 (o_word),
      .o_word_bytes           (o_word_bytes),
      .i_word_ready           (i_word_ready),
      .o_timeout_err          (o_timeout_err)
   );

   typedef struct {
      logic [7:0] gray;
      int         lat;
      bit         drop;
   } resp_t;

   typedef struct {
      logic [31:0] word;
      logic [2:0]  bytes;
   } word_t;

   resp_t       resp_q[$];
   logic [31:0] pix_q[$];
   word_t       exp_q[$];

   int checks      = 0;
   int errors      = 0;
   int words_seen  = 0;
   int starts_seen = 0;

   logic [31:0] model_word = '0;
   int          model_idx  = 0;

   bit          pending = 1'b0;
   int          cnt = 0;
   logic [7:0]  pend_gray;
   logic [31:0] rgb_at_start;
   logic        prev_start = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Behavioural grayscale unit. Outputs are sampled and inputs driven on the falling edge.
   initial begin
      i_grayscale_data_ready = 1'b0;
      i_gray = 8'h00;
      forever begin
         @(negedge clk);
         i_grayscale_data_ready = 1'b0;
         if (!n_rst) begin
            pending    = 1'b0;
            prev_start = 1'b0;
         end else begin
            if (pending) begin
               if (cnt == 1) begin
                  i_grayscale_data_ready = 1'b1;
                  i_gray  = pend_gray;
                  pending = 1'b0;
                  check("rgb_stable_wait", o_RGB, rgb_at_start);
                  check("pix_ready_low_wait", 32'(o_pix_ready), 32'd0);
               end else begin
                  cnt--;
               end
            end
            if (o_grayscale_start) begin
               resp_t       r;
               logic [31:0] px;
               starts_seen++;
               check("start_pulse_width", 32'(prev_start), 32'd0);
               check("pix_ready_low_issue", 32'(o_pix_ready), 32'd0);
               check("start_expected", 32'(resp_q.size() != 0 && pix_q.size() != 0), 32'd1);
               if (resp_q.size() != 0 && pix_q.size() != 0) begin
                  r  = resp_q.pop_front();
                  px = pix_q.pop_front();
                  check("issue_rgb", o_RGB, px);
                  rgb_at_start = o_RGB;
                  if (!r.drop) begin
                     pending   = 1'b1;
                     cnt       = r.lat;
                     pend_gray = r.gray;
                  end
               end
            end
            prev_start = o_grayscale_start;
         end
      end
   end

   // Word collector. It pops the scoreboard on each handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (n_rst && o_word_valid && i_word_ready) begin
            word_t w;
            words_seen++;
            check("pix_ready_low_out", 32'(o_pix_ready), 32'd0);
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("word", o_word, w.word);
               check("word_bytes", 32'(o_word_bytes), 32'(w.bytes));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_add(input logic [7:0] b);
      word_t w;
      model_word[31 - 8*model_idx -: 8] = b;
      model_idx++;
      if (model_idx == 4) begin
         w.word  = model_word;
         w.bytes = 3'd4;
         exp_q.push_back(w);
         model_word = '0;
         model_idx  = 0;
      end
   endtask

   task automatic send_pixel(input logic [31:0] rgb, input logic [7:0] gray,
                             input int lat, input bit drop, input bit keep);
      int    budget;
      resp_t r;
      budget      = 0;
      i_pix_valid = 1'b1;
      i_pix_RGB   = rgb;
      while (!o_pix_ready && budget < 200) begin
         tick();
         budget++;
      end
      check("pix_accept", 32'(o_pix_ready), 32'd1);
      if (o_pix_ready) begin
         r.gray = gray;
         r.lat  = lat;
         r.drop = drop;
         pix_q.push_back(rgb);
         resp_q.push_back(r);
         model_add(drop ? 8'h00 : gray);
         tick();
      end
      if (!keep) i_pix_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (!(o_pix_ready && resp_q.size() == 0 && !pending && exp_q.size() == 0) && n < 300) begin
         tick();
         n++;
      end
      check("drain", 32'(n < 300), 32'd1);
   endtask

   task automatic do_flush();
      word_t w;
      i_flush = 1'b1;
      if (model_idx != 0) begin
         w.word  = model_word;
         w.bytes = 3'(model_idx);
         exp_q.push_back(w);
         model_word = '0;
         model_idx  = 0;
      end
      tick();
      i_flush = 1'b0;
   endtask

   task automatic clear_model();
      resp_q.delete();
      pix_q.delete();
      exp_q.delete();
      model_word = '0;
      model_idx  = 0;
      pending    = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_start"}, 32'(o_grayscale_start), 32'd0);
      check({tag, "_rgb"}, o_RGB, 32'd0);
      check({tag, "_word_valid"}, 32'(o_word_valid), 32'd0);
      check({tag, "_word"}, o_word, 32'd0);
      check({tag, "_word_bytes"}, 32'(o_word_bytes), 32'd0);
      check({tag, "_timeout_err"}, 32'(o_timeout_err), 32'd0);
   endtask

   initial begin
      int w0;
      int s0;
      int n;

      // 1: reset, reset in the middle of WAIT, then a fresh word packs from slot 0
      n_rst        = 1'b0;
      i_pix_valid  = 1'b0;
      i_pix_RGB    = '0;
      i_flush      = 1'b0;
      i_word_ready = 1'b1;
      tick(2);
      check_reset_outputs("rst");
      n_rst = 1'b1;
      tick();
      check("pix_ready_after_reset", 32'(o_pix_ready), 32'd1);

      send_pixel(32'hA1A1A100, 8'hA1, 2, 1'b0, 1'b0);
      send_pixel(32'hA2A2A200, 8'hA2, 2, 1'b0, 1'b0);
      wait_drain();
      send_pixel(32'hA3A3A300, 8'hA3, 20, 1'b0, 1'b0);
      tick(4);
      n_rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      clear_model();
      tick(2);
      n_rst = 1'b1;
      tick();
      check("pix_ready_after_mid_reset", 32'(o_pix_ready), 32'd1);
      send_pixel(32'h11111100, 8'h11, 1, 1'b0, 1'b0);
      send_pixel(32'h22222200, 8'h22, 1, 1'b0, 1'b0);
      send_pixel(32'h33333300, 8'h33, 1, 1'b0, 1'b0);
      send_pixel(32'h44444400, 8'h44, 1, 1'b0, 1'b0);
      wait_drain();

      // 2: four pixels with 3-cycle latency; the word is held while downstream stalls
      i_word_ready = 1'b0;
      s0 = starts_seen;
      send_pixel(32'hC8641E00, 8'h96, 3, 1'b0, 1'b0);
      send_pixel(32'h1E64C800, 8'h69, 3, 1'b0, 1'b0);
      send_pixel(32'h64C81E00, 8'h84, 3, 1'b0, 1'b0);
      send_pixel(32'hFAF0E600, 8'hF2, 3, 1'b0, 1'b0);
      n = 0;
      while (!o_word_valid && n < 50) begin
         tick();
         n++;
      end
      check("word_valid_rise", 32'(o_word_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         check("word_valid_held", 32'(o_word_valid), 32'd1);
         check("word_held", o_word, 32'h966984F2);
         tick();
      end
      check("word_bytes_held", 32'(o_word_bytes), 32'd4);
      i_word_ready = 1'b1;
      tick();
      check("word_valid_cleared", 32'(o_word_valid), 32'd0);
      check("word_cleared", o_word, 32'd0);
      check("start_count_4", 32'(starts_seen - s0), 32'd4);
      wait_drain();

      // 3: flushing a partial word, then a flush with nothing buffered
      w0 = words_seen;
      send_pixel(32'h64646400, 8'h64, 2, 1'b0, 1'b0);
      send_pixel(32'hFFFFFF00, 8'hFF, 2, 1'b0, 1'b0);
      wait_drain();
      do_flush();
      wait_drain();
      check("flush_word_count", 32'(words_seen - w0), 32'd1);
      w0 = words_seen;
      do_flush();
      for (int i = 0; i < 3; i++) begin
         check("empty_flush_no_valid", 32'(o_word_valid), 32'd0);
         tick();
      end
      check("empty_flush_word_count", 32'(words_seen - w0), 32'd0);

      // 4: a result on the last WAIT cycle still counts; a missing result times out
      check("timeout_err_clear", 32'(o_timeout_err), 32'd0);
      send_pixel(32'h7B7B7B00, 8'h7B, TIMEOUT, 1'b0, 1'b0);
      wait_drain();
      check("no_err_on_boundary", 32'(o_timeout_err), 32'd0);
      send_pixel(32'h12345600, 8'h55, 1, 1'b1, 1'b0);
      tick(TIMEOUT);
      check("timeout_err_not_yet", 32'(o_timeout_err), 32'd0);
      tick();
      check("timeout_err_set", 32'(o_timeout_err), 32'd1);
      send_pixel(32'h7B7B7B00, 8'h7B, 1, 1'b0, 1'b0);
      send_pixel(32'h7B7B7B00, 8'h7B, 1, 1'b0, 1'b0);
      wait_drain();
      check("timeout_err_sticky", 32'(o_timeout_err), 32'd1);

      // 5: i_pix_valid held high continuously with 1-cycle latency, 12 pixels
      w0 = words_seen;
      s0 = starts_seen;
      for (int i = 0; i < 12; i++) begin
         send_pixel({8'(i), 8'(i + 1), 8'(i + 2), 8'h00}, 8'(8'h10 + i), 1, 1'b0, 1'b1);
      end
      i_pix_valid = 1'b0;
      wait_drain();
      check("stream_word_count", 32'(words_seen - w0), 32'd3);
      check("stream_start_count", 32'(starts_seen - s0), 32'd12);

      // 6: flush and pixel together in IDLE with one byte buffered
      w0 = words_seen;
      send_pixel(32'hABABAB00, 8'hAB, 1, 1'b0, 1'b0);
      wait_drain();
      i_word_ready = 1'b0;
      i_pix_valid  = 1'b1;
      i_pix_RGB    = 32'hC0C0C000;
      i_flush      = 1'b1;
      #1;
      check("flush_blocks_pix_ready", 32'(o_pix_ready), 32'd0);
      do_flush();
      check("flush_wins_valid", 32'(o_word_valid), 32'd1);
      check("flush_wins_bytes", 32'(o_word_bytes), 32'd1);
      check("flush_wins_word", o_word, 32'hAB000000);
      tick(2);
      check("pix_not_accepted_in_out", 32'(o_grayscale_start), 32'd0);
      check("pix_not_accepted_rgb", o_RGB, 32'hABABAB00);
      i_word_ready = 1'b1;
      send_pixel(32'hC0C0C000, 8'hCD, 1, 1'b0, 1'b0);
      wait_drain();
      do_flush();
      wait_drain();
      check("flush_pix_word_count", 32'(words_seen - w0), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
